// File: rtl/font_rom_arbiter_if.sv
// Bundle between the font ROM arbiter, its two text-overlay requesters and the shared font ROM.
// The slave modport is the arbiter's view; master is the requesters-plus-ROM side.
interface font_rom_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              gnt0;
  logic [DATA_W-1:0] data0;
  logic              vld0;

  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              gnt1;
  logic [DATA_W-1:0] data1;
  logic              vld1;

  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  modport slave (
    input  req0, addr0, req1, addr1, rom_data,
    output gnt0, data0, vld0, gnt1, data1, vld1, rom_addr
  );

  modport master (
    output req0, addr0, req1, addr1, rom_data,
    input  gnt0, data0, vld0, gnt1, data1, vld1, rom_addr
  );
endinterface

// File: rtl/font_rom_arbiter.sv
// Two-requester arbiter for a single synchronous font ROM (1-cycle read latency),
// returning each row word to its issuer two clocks after the grant.
module font_rom_arbiter #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 8,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic clk,
  input  logic reset,
  font_rom_arbiter_if.slave bus
);

  logic [1:0]        req;
  logic [ADDR_W-1:0] addr [2];
  logic [1:0]        gnt;
  logic [ADDR_W-1:0] rom_addr;

  logic last_q, last_d;
  logic t1_vld_q, t1_vld_d;
  logic t1_id_q, t1_id_d;

  logic [DATA_W-1:0] data_q [2];
  logic [DATA_W-1:0] data_d [2];
  logic              vld_q  [2];
  logic              vld_d  [2];

  assign req     = {bus.req1, bus.req0};
  assign addr[0] = bus.addr0;
  assign addr[1] = bus.addr1;

  // last_q holds the index granted most recently; on contention the other one wins
  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      if (req[0] && req[1]) begin
        if (ROUND_ROBIN && !last_q) gnt = 2'b10;
        else                        gnt = 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  always_comb begin
    rom_addr = '0;
    if (gnt[0])      rom_addr = addr[0];
    else if (gnt[1]) rom_addr = addr[1];
  end

  always_comb begin
    last_d   = last_q;
    if (gnt[0])      last_d = 1'b0;
    else if (gnt[1]) last_d = 1'b1;
    t1_vld_d = |gnt;
    t1_id_d  = gnt[1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q   <= 1'b1;
      t1_vld_q <= 1'b0;
      t1_id_q  <= 1'b0;
    end else begin
      last_q   <= last_d;
      t1_vld_q <= t1_vld_d;
      t1_id_q  <= t1_id_d;
    end
  end

  // Return stage: rom_data is valid the cycle after the grant, steered by the stage-1 tag
  for (genvar gi = 0; gi < 2; gi++) begin : g_ret
    always_comb begin
      vld_d[gi]  = t1_vld_q && (t1_id_q == 1'(gi));
      data_d[gi] = data_q[gi];
      if (vld_d[gi]) data_d[gi] = bus.rom_data;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        data_q[gi] <= '0;
        vld_q[gi]  <= 1'b0;
      end else begin
        data_q[gi] <= data_d[gi];
        vld_q[gi]  <= vld_d[gi];
      end
    end
  end

  assign bus.gnt0     = gnt[0];
  assign bus.gnt1     = gnt[1];
  assign bus.rom_addr = rom_addr;
  assign bus.data0    = data_q[0];
  assign bus.vld0     = vld_q[0];
  assign bus.data1    = data_q[1];
  assign bus.vld1     = vld_q[1];

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed bench for font_rom_arbiter: a round-robin and a fixed-priority instance
// share clock, reset and stimulus, each backed by its own behavioural font ROM.
module tb_font_rom_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  font_rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_rr ();
  font_rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_fp ();

  font_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROUND_ROBIN(1'b1)) dut_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_rr.slave)
  );

  font_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROUND_ROBIN(1'b0)) dut_fp (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_fp.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM contents: low address byte XOR {char[6:4], 5'b10110}; e.g. 0x523 -> 0x95, 0x430 -> 0xA6, 0x4D0 -> 0x46
  function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ {a[10:8], 5'b10110};
  endfunction

  initial begin
    bus_rr.rom_data = '0;
    bus_fp.rom_data = '0;
  end

  always @(posedge clk) begin
    bus_rr.rom_data <= rom_fn(bus_rr.rom_addr);
    bus_fp.rom_data <= rom_fn(bus_fp.rom_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic [ADDR_W-1:0] a0,
                       input logic r1, input logic [ADDR_W-1:0] a1);
    bus_rr.req0 = r0; bus_rr.addr0 = a0; bus_rr.req1 = r1; bus_rr.addr1 = a1;
    bus_fp.req0 = r0; bus_fp.addr0 = a0; bus_fp.req1 = r1; bus_fp.addr1 = a1;
    #1;
  endtask

  task automatic check_idle_rr(input string tag);
    check({tag, "_gnt"},  {30'd0, bus_rr.gnt1, bus_rr.gnt0}, 32'd0);
    check({tag, "_vld"},  {30'd0, bus_rr.vld1, bus_rr.vld0}, 32'd0);
    check({tag, "_data"}, {16'd0, bus_rr.data1, bus_rr.data0}, 32'd0);
    check({tag, "_addr"}, 32'(bus_rr.rom_addr), 32'd0);
  endtask

  logic exp_g [6];
  logic g_prev;

  initial begin
    checks   = 0;
    failures = 0;
    exp_g    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    reset    = 1'b1;
    drive(1'b1, 11'h123, 1'b1, 11'h456);

    // Reset held 3 cycles; grants must be suppressed even with requests present
    for (int i = 0; i < 3; i++) begin
      check_idle_rr("reset");
      check("reset_fp_gnt", {30'd0, bus_fp.gnt1, bus_fp.gnt0}, 32'd0);
      $display("reset cycle %0d", i);
      step();
    end
    drive(1'b0, '0, 1'b0, '0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_idle_rr("idle");
      $display("idle cycle %0d", i);
    end

    // Single requester 0
    step();
    drive(1'b1, 11'h523, 1'b0, '0);
    check("single_gnt0", 32'(bus_rr.gnt0), 32'd1);
    check("single_gnt1", 32'(bus_rr.gnt1), 32'd0);
    check("single_addr", 32'(bus_rr.rom_addr), 32'h523);
    step();
    drive(1'b0, '0, 1'b0, '0);
    check("single_vld0_early", 32'(bus_rr.vld0), 32'd0);
    step();
    check("single_vld0", 32'(bus_rr.vld0), 32'd1);
    check("single_data0", 32'(bus_rr.data0), 32'h95);
    check("single_vld1", 32'(bus_rr.vld1), 32'd0);
    step();
    check("single_vld0_drop", 32'(bus_rr.vld0), 32'd0);
    check("single_data0_hold", 32'(bus_rr.data0), 32'h95);
    $display("single read 0x523 -> data0=0x%0h", bus_rr.data0);

    // Back-to-back streaming on requester 1
    for (int i = 0; i < 18; i++) begin
      step();
      if (i < 16) drive(1'b0, '0, 1'b1, 11'(11'h560 + i));
      else        drive(1'b0, '0, 1'b0, '0);
      if (i < 16) begin
        check("stream_gnt1", 32'(bus_rr.gnt1), 32'd1);
        check("stream_addr", 32'(bus_rr.rom_addr), 32'(11'h560 + i));
      end
      if (i >= 2) begin
        check("stream_vld1", 32'(bus_rr.vld1), 32'd1);
        check("stream_data1", 32'(bus_rr.data1), 32'(rom_fn(11'(11'h560 + i - 2))));
      end else begin
        check("stream_vld1_early", 32'(bus_rr.vld1), 32'd0);
      end
      check("stream_vld0", 32'(bus_rr.vld0), 32'd0);
      $display("stream cycle %0d gnt1=%0b vld1=%0b data1=0x%0h", i, bus_rr.gnt1, bus_rr.vld1, bus_rr.data1);
    end
    step();
    check("stream_vld1_end", 32'(bus_rr.vld1), 32'd0);

    // Contention: RR alternates starting with 0 (last grant was requester 1); FP always grants 0
    for (int i = 0; i < 8; i++) begin
      step();
      if (i < 6) drive(1'b1, 11'h430, 1'b1, 11'h4D0);
      else       drive(1'b0, '0, 1'b0, '0);
      if (i < 6) begin
        check("rr_gnt0", 32'(bus_rr.gnt0), 32'(!exp_g[i]));
        check("rr_gnt1", 32'(bus_rr.gnt1), 32'(exp_g[i]));
        check("rr_addr", 32'(bus_rr.rom_addr), exp_g[i] ? 32'h4D0 : 32'h430);
        check("fp_gnt",  {30'd0, bus_fp.gnt1, bus_fp.gnt0}, 32'd1);
      end
      if (i >= 2) begin
        g_prev = exp_g[i-2];
        check("rr_vld0", 32'(bus_rr.vld0), 32'(!g_prev));
        check("rr_vld1", 32'(bus_rr.vld1), 32'(g_prev));
        if (g_prev) check("rr_data1", 32'(bus_rr.data1), 32'h46);
        else        check("rr_data0", 32'(bus_rr.data0), 32'hA6);
        check("fp_vld0", 32'(bus_fp.vld0), 32'd1);
        check("fp_data0", 32'(bus_fp.data0), 32'hA6);
      end
      check("fp_vld1", 32'(bus_fp.vld1), 32'd0);
      $display("contention cycle %0d rr_gnt=%0b%0b fp_gnt=%0b%0b rr_vld=%0b%0b",
               i, bus_rr.gnt1, bus_rr.gnt0, bus_fp.gnt1, bus_fp.gnt0, bus_rr.vld1, bus_rr.vld0);
    end

    // Reset mid-flight: grant req0 (pointer -> 0), then reset the cycle after
    step();
    drive(1'b1, 11'h523, 1'b0, '0);
    check("mid_gnt0", 32'(bus_rr.gnt0), 32'd1);
    step();
    drive(1'b0, '0, 1'b0, '0);
    reset = 1'b1;
    #1;
    check("mid_data0_clr", 32'(bus_rr.data0), 32'd0);
    check("mid_vld0", 32'(bus_rr.vld0), 32'd0);
    step();
    check("mid_vld0_n2", 32'(bus_rr.vld0), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("mid_after_vld0", 32'(bus_rr.vld0), 32'd0);
      check("mid_after_data0", 32'(bus_rr.data0), 32'd0);
    end
    step();
    drive(1'b1, 11'h430, 1'b1, 11'h4D0);
    check("mid_first_gnt0", 32'(bus_rr.gnt0), 32'd1);
    check("mid_first_gnt1", 32'(bus_rr.gnt1), 32'd0);
    step();
    check("mid_second_gnt1", 32'(bus_rr.gnt1), 32'd1);
    drive(1'b0, '0, 1'b0, '0);
    $display("reset mid-flight: data0=0x%0h after release", bus_rr.data0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/font_rom_arbiter.md
Name: font_rom_arbiter

Overview:
Shares one synchronous font ROM (11-bit address = {char[6:0], row[3:0]}, 8-bit row word, 1-cycle read latency) between two text-overlay requesters, e.g. the centred banner renderer and a status-line renderer. It grants at most one requester per clock and drives the ROM address. It pipelines the returned row word back to the requester that issued the read, tagged with a valid strobe. Fixed-priority or round-robin arbitration is selectable by parameter.

Parameters:
ADDR_W, 11, font ROM address width ({char_addr, row_addr})
DATA_W, 8, font ROM row-word width
ROUND_ROBIN, 1, 1 = alternate on contention; 0 = requester 0 always wins

Ports:
clk  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
req0  in  1  requester 0 read request (level, sampled each cycle)
addr0  in  ADDR_W  requester 0 ROM address, valid while req0=1
gnt0  out  1  requester 0 granted this cycle (combinational)
data0  out  DATA_W  row word returned to requester 0 (registered, held)
vld0  out  1  one-cycle strobe: data0 updated this cycle
req1  in  1  requester 1 read request
addr1  in  ADDR_W  requester 1 ROM address
gnt1  out  1  requester 1 granted this cycle
data1  out  DATA_W  row word returned to requester 1
vld1  out  1  one-cycle strobe: data1 updated this cycle
rom_addr  out  ADDR_W  address to font ROM (combinational mux)
rom_data  in  DATA_W  ROM output, valid 1 cycle after rom_addr

Behaviour:
- Reset (async assert, sync release): data0=data1=0, vld0=vld1=0, pipeline tags cleared, priority pointer last=1 (requester 0 wins first contention). gnt0/gnt1 are combinational and follow their equations during reset but are qualified by reset: gnt0=gnt1=0 while reset=1. rom_addr=0 while reset=1.
- Grant (cycle N, combinational):
  - Only req0: gnt0=1. Only req1: gnt1=1. Neither: no grant, rom_addr=0.
  - Both, ROUND_ROBIN=1: grant the requester not equal to last.
  - Both, ROUND_ROBIN=0: gnt0=1.
- gnt0 and gnt1 are never both 1. rom_addr = addr of the granted requester.
- Pointer: on any grant, last <= index of granted requester. With no grant, last holds.
- Pipeline:
  - Stage 1 (N->N+1): register t1_vld=(gnt0|gnt1) and t1_id=granted index.
  - Cycle N+1: rom_data is valid.
  - Stage 2 (N+1->N+2): if t1_vld, data[t1_id] <= rom_data and vld[t1_id] <= 1, else both vld <= 0.
  - Total latency from grant to vld/data: 2 clocks. One read per clock is sustained; no bubbles.
- dataN holds its last value until the next vldN. vldN is exactly one cycle per granted read.
- A requester that is not granted must hold req/addr; the arbiter keeps no request queue.
- Continuous contention with ROUND_ROBIN=1: grants alternate 0,1,0,1…, and each requester gets exactly 1 of every 2 cycles.
- Dropping a request in the grant cycle is legal: the read is already issued and the data still returns.
- Reset mid-operation: in-flight tags are discarded, no vld is produced for them, and data is cleared to 0.
- Address width is passed through unmodified; no arithmetic. Out-of-range addresses do not exist (full 2^ADDR_W ROM).

Test Plan:
- Reset then idle: reset=1 for 3 cycles, release, no req for 5 cycles -> gnt0=gnt1=0, vld0=vld1=0, data0=data1=0, rom_addr=0 throughout.
- Single requester: req0=1, addr0=0x523 ('R' row 3) for one cycle -> gnt0=1 that cycle, rom_addr=0x523. Two cycles later vld0=1 for one cycle and data0 = ROM[0x523]; vld1 stays 0.
- Contention RR: req0=req1=1 for 6 cycles, addr0=0x430, addr1=0x4D0 -> gnt sequence 0,1,0,1,0,1. vld0 and vld1 alternate from cycle 2, with data0=ROM[0x430] and data1=ROM[0x4D0].
- Fixed priority: ROUND_ROBIN=0, both requesting for 4 cycles -> gnt0=1 every cycle, gnt1=0, vld1 never asserts.
- Back-to-back streaming: req1 held, addr1 stepping 0x560..0x56F, one per cycle -> 16 consecutive vld1 pulses with data1 = ROM[0x560..0x56F] in order, latency 2 each.
- Reset mid-flight: grant req0 at cycle N, assert reset at N+1 -> no vld0 is produced, data0=0, and after release the first contention grants requester 0.
